// File: rtl/key_event_unit.sv
// Multi-channel push-button front end: synchroniser, debouncer, edge pulse
// stretcher, long-press strobe and sticky event flags feeding one interrupt.
module key_event_unit #(
    parameter int    WIDTH         = 2,
    parameter string POLARITY      = "LOW",
    parameter int    TIMEOUT       = 50000,
    parameter int    TIMEOUT_WIDTH = 16,
    parameter int    EDGE_TYPE     = 1,
    parameter int    PULSE_EXT     = 1,
    parameter int    LONG_TIMEOUT  = 50000000,
    parameter int    LONG_WIDTH    = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] key_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pulse_out,
    output logic [WIDTH-1:0] long_pulse,
    output logic [WIDTH-1:0] evt_press,
    output logic [WIDTH-1:0] evt_release,
    output logic [WIDTH-1:0] evt_long,
    input  logic [WIDTH-1:0] evt_clr,
    output logic             irq
);

    localparam logic IDLE_RAW = (POLARITY == "LOW");
    localparam int   EXT_W    = $clog2(PULSE_EXT + 1);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] act;

    // Synchroniser resets to the idle raw level so reset never looks like a press
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= {WIDTH{IDLE_RAW}};
            sync_p1 <= {WIDTH{IDLE_RAW}};
        end else begin
            sync_p0 <= key_in;
            sync_p1 <= sync_p0;
        end
    end

    assign act = IDLE_RAW ? ~sync_p1 : sync_p1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic                     state;
        logic                     state_d;
        logic                     rise;
        logic                     fall;
        logic                     sel_edge;
        logic                     long_hit;
        logic                     long_done;
        logic                     long_strobe;
        logic                     flag_press;
        logic                     flag_release;
        logic                     flag_long;
        logic [TIMEOUT_WIDTH-1:0] db_cnt;
        logic [EXT_W-1:0]         ext_cnt;
        logic [LONG_WIDTH-1:0]    long_cnt;

        assign rise     = state & ~state_d;
        assign fall     = ~state & state_d;
        assign sel_edge = (EDGE_TYPE == 0) ? fall :
                          (EDGE_TYPE == 1) ? rise : (rise | fall);
        assign long_hit = state && (long_cnt == LONG_WIDTH'(LONG_TIMEOUT - 1));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state        <= 1'b0;
                state_d      <= 1'b0;
                db_cnt       <= '0;
                ext_cnt      <= '0;
                long_cnt     <= '0;
                long_done    <= 1'b0;
                long_strobe  <= 1'b0;
                flag_press   <= 1'b0;
                flag_release <= 1'b0;
                flag_long    <= 1'b0;
            end else begin
                if (act[i] == state) begin
                    db_cnt <= '0;
                end else if (db_cnt == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
                    state  <= act[i];
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
                state_d <= state;

                // Reload rather than queue: overlapping edges stretch one pulse
                if (sel_edge) begin
                    ext_cnt <= EXT_W'(PULSE_EXT);
                end else if (ext_cnt != '0) begin
                    ext_cnt <= ext_cnt - 1'b1;
                end

                // Counter saturates; long_done keeps the strobe to one per press
                if (!state) begin
                    long_cnt  <= '0;
                    long_done <= 1'b0;
                end else if (!long_hit) begin
                    long_cnt <= long_cnt + 1'b1;
                end else begin
                    long_done <= 1'b1;
                end
                long_strobe <= long_hit && !long_done;

                flag_press   <= rise | (flag_press & ~evt_clr[i]);
                flag_release <= fall | (flag_release & ~evt_clr[i]);
                flag_long    <= long_strobe | (flag_long & ~evt_clr[i]);
            end
        end

        assign level[i]       = state;
        assign pulse_out[i]   = (ext_cnt != '0);
        assign long_pulse[i]  = long_strobe;
        assign evt_press[i]   = flag_press;
        assign evt_release[i] = flag_release;
        assign evt_long[i]    = flag_long;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |{evt_press, evt_release, evt_long};
        end
    end

endmodule

// File: tb/tb_key_event_unit.sv
// Self-checking bench for key_event_unit: directed timing scenarios plus a
// randomized run compared against a timestamp-based reference model.
module tb_key_event_unit;

    localparam int T  = 4;
    localparam int PE = 3;
    localparam int LT = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key_in = 2'b11;
    logic [1:0] evt_clr = 2'b00;
    logic [1:0] level, pulse_out, long_pulse, evt_press, evt_release, evt_long;
    logic       irq;

    logic [1:0] key2 = 2'b11;
    logic [1:0] clr2 = 2'b00;
    logic [1:0] level2, pulse2, long2, press2, release2, elong2;
    logic       irq2;

    int total = 0;
    int passed = 0;

    key_event_unit #(
        .WIDTH(2), .POLARITY("LOW"), .TIMEOUT(T), .TIMEOUT_WIDTH(4),
        .EDGE_TYPE(1), .PULSE_EXT(PE), .LONG_TIMEOUT(LT), .LONG_WIDTH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .level(level),
        .pulse_out(pulse_out), .long_pulse(long_pulse), .evt_press(evt_press),
        .evt_release(evt_release), .evt_long(evt_long), .evt_clr(evt_clr), .irq(irq)
    );

    key_event_unit #(
        .WIDTH(2), .POLARITY("LOW"), .TIMEOUT(2), .TIMEOUT_WIDTH(2),
        .EDGE_TYPE(2), .PULSE_EXT(3), .LONG_TIMEOUT(LT), .LONG_WIDTH(5)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .key_in(key2), .level(level2),
        .pulse_out(pulse2), .long_pulse(long2), .evt_press(press2),
        .evt_release(release2), .evt_long(elong2), .evt_clr(clr2), .irq(irq2)
    );

    always #5 clk = ~clk;

    // Reference model: level from run lengths of the pressed history, all
    // other outputs from timestamps of accepted level changes.
    int         mt = 0;
    logic [1:0] kh1 = 2'b11, kh2 = 2'b11;
    logic [1:0] m_level = '0, m_pulse = '0, m_long = '0;
    logic [1:0] m_fp = '0, m_fr = '0, m_fl = '0;
    logic       m_irq = 1'b0;
    int         run[2], chg_t[2], press_t[2], sel_t[2], sel_prev[2];
    logic       chg_up[2];

    task automatic model_step();
        logic act, nirq;
        int   c;
        mt++;
        if (!rst_n) begin
            kh1 = 2'b11; kh2 = 2'b11;
            m_level = '0; m_pulse = '0; m_long = '0;
            m_fp = '0; m_fr = '0; m_fl = '0; m_irq = 1'b0;
            for (int i = 0; i < 2; i++) begin
                run[i] = 0; chg_t[i] = -100; press_t[i] = -1000;
                sel_t[i] = -1000; sel_prev[i] = -1000; chg_up[i] = 1'b0;
            end
            return;
        end
        nirq = |{m_fp, m_fr, m_fl};
        for (int i = 0; i < 2; i++) begin
            act = ~kh2[i];
            m_fp[i] = (chg_t[i] == mt - 1 && chg_up[i])  | (m_fp[i] & ~evt_clr[i]);
            m_fr[i] = (chg_t[i] == mt - 1 && !chg_up[i]) | (m_fr[i] & ~evt_clr[i]);
            m_fl[i] = m_long[i] | (m_fl[i] & ~evt_clr[i]);
            m_long[i] = m_level[i] && (mt - press_t[i] == LT);
            if (act != m_level[i]) begin
                run[i]++;
                if (run[i] == T) begin
                    m_level[i] = act; run[i] = 0; chg_t[i] = mt; chg_up[i] = act;
                    if (act) begin
                        press_t[i] = mt; sel_prev[i] = sel_t[i]; sel_t[i] = mt;
                    end
                end
            end else begin
                run[i] = 0;
            end
            c = (sel_t[i] == mt) ? sel_prev[i] : sel_t[i];
            m_pulse[i] = (mt - c >= 1) && (mt - c <= PE);
        end
        m_irq = nirq;
        kh2 = kh1; kh1 = key_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total++;
        if ({level, pulse_out, long_pulse, evt_press, evt_release, evt_long, irq} !== 13'd0)
            $display("FAIL reset_outputs got %b exp 0",
                     {level, pulse_out, long_pulse, evt_press, evt_release, evt_long, irq});
        else passed++;
        total++;
        if ({level2, pulse2, long2, press2, release2, elong2, irq2} !== 13'd0)
            $display("FAIL reset_outputs2 got %b exp 0",
                     {level2, pulse2, long2, press2, release2, elong2, irq2});
        else passed++;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        total++;
        if ({level, pulse_out, evt_press, evt_release, irq} !== 9'd0)
            $display("FAIL reset_release_quiet got %b exp 0",
                     {level, pulse_out, evt_press, evt_release, irq});
        else passed++;
    endtask

    task automatic test_press_timing();
        key_in[0] = 1'b0;
        tick();
        for (int e = 1; e <= 10; e++) begin
            tick();
            total++;
            if (level[0] !== (e >= 5)) $display("FAIL press_level e=%0d got %b exp %b", e, level[0], e >= 5);
            else passed++;
            total++;
            if (pulse_out[0] !== (e >= 6 && e <= 8))
                $display("FAIL press_pulse e=%0d got %b exp %b", e, pulse_out[0], e >= 6 && e <= 8);
            else passed++;
            total++;
            if (evt_press[0] !== (e >= 6)) $display("FAIL press_evt e=%0d got %b exp %b", e, evt_press[0], e >= 6);
            else passed++;
            total++;
            if (irq !== (e >= 7)) $display("FAIL press_irq e=%0d got %b exp %b", e, irq, e >= 7);
            else passed++;
        end
    endtask

    task automatic test_long_press();
        for (int e = 11; e <= 35; e++) begin
            tick();
            total++;
            if (long_pulse[0] !== (e == 15)) $display("FAIL long_pulse e=%0d got %b exp %b", e, long_pulse[0], e == 15);
            else passed++;
            total++;
            if (evt_long[0] !== (e >= 16)) $display("FAIL long_evt e=%0d got %b exp %b", e, evt_long[0], e >= 16);
            else passed++;
        end
        evt_clr[0] = 1'b1;
        tick();
        evt_clr[0] = 1'b0;
        total++;
        if ({evt_press[0], evt_long[0]} !== 2'b00)
            $display("FAIL long_clear got %b exp 00", {evt_press[0], evt_long[0]});
        else passed++;
        key_in[0] = 1'b1;
        tick();
        for (int e = 1; e <= 10; e++) begin
            tick();
            total++;
            if (level[0] !== (e < 5)) $display("FAIL release_level e=%0d got %b exp %b", e, level[0], e < 5);
            else passed++;
            total++;
            if (pulse_out[0] !== 1'b0) $display("FAIL release_no_pulse e=%0d got %b exp 0", e, pulse_out[0]);
            else passed++;
            total++;
            if (evt_release[0] !== (e >= 6)) $display("FAIL release_evt e=%0d got %b exp %b", e, evt_release[0], e >= 6);
            else passed++;
        end
    endtask

    task automatic test_bounce();
        logic [10:0] seq;
        seq = 11'b00000001000;
        for (int k = 0; k < 3; k++) tick();
        for (int k = 0; k <= 10; k++) begin
            key_in[0] = seq[k];
            tick();
            total++;
            if (level[0] !== (k >= 9)) $display("FAIL bounce_level k=%0d got %b exp %b", k, level[0], k >= 9);
            else passed++;
        end
    endtask

    task automatic test_clear();
        for (int k = 0; k < 12; k++) tick();
        evt_clr[0] = 1'b1;
        tick();
        evt_clr[0] = 1'b0;
        key_in[0] = 1'b1;
        tick();
        for (int e = 1; e <= 5; e++) tick();
        evt_clr[0] = 1'b1;
        tick();
        evt_clr[0] = 1'b0;
        total++;
        if ({evt_press[0], evt_release[0], evt_long[0]} !== 3'b010)
            $display("FAIL clear_set_wins got %b exp 010", {evt_press[0], evt_release[0], evt_long[0]});
        else passed++;
        tick();
        total++;
        if (irq !== 1'b1) $display("FAIL clear_irq_high got %b exp 1", irq);
        else passed++;
        evt_clr[0] = 1'b1;
        tick();
        evt_clr[0] = 1'b0;
        total++;
        if ({evt_press, evt_release, evt_long} !== 6'd0)
            $display("FAIL clear_flags got %b exp 0", {evt_press, evt_release, evt_long});
        else passed++;
        total++;
        if (irq !== 1'b1) $display("FAIL clear_irq_lag got %b exp 1", irq);
        else passed++;
        tick();
        total++;
        if (irq !== 1'b0) $display("FAIL clear_irq_low got %b exp 0", irq);
        else passed++;
    endtask

    task automatic test_reset_mid();
        key_in[1] = 1'b0;
        tick();
        for (int e = 1; e <= 6; e++) begin
            if (e == 4) key_in[0] = 1'b0;
            tick();
        end
        rst_n = 1'b0;
        tick();
        total++;
        if ({level, pulse_out, long_pulse, evt_press, evt_release, evt_long, irq} !== 13'd0)
            $display("FAIL reset_mid got %b exp 0",
                     {level, pulse_out, long_pulse, evt_press, evt_release, evt_long, irq});
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
        for (int e = 1; e <= 7; e++) begin
            tick();
            total++;
            if (level !== ((e >= 5) ? 2'b11 : 2'b00))
                $display("FAIL reset_mid_level e=%0d got %b exp %b", e, level, (e >= 5) ? 2'b11 : 2'b00);
            else passed++;
            total++;
            if ({pulse_out, evt_press} !== ((e >= 6) ? 4'b1111 : 4'b0000))
                $display("FAIL reset_mid_evt e=%0d got %b", e, {pulse_out, evt_press});
            else passed++;
        end
    endtask

    task automatic test_edge_both();
        key2[0] = 1'b0;
        tick();
        tick();
        key2[0] = 1'b1;
        for (int e = 2; e <= 10; e++) begin
            tick();
            total++;
            if (level2[0] !== (e == 3 || e == 4))
                $display("FAIL both_level e=%0d got %b exp %b", e, level2[0], e == 3 || e == 4);
            else passed++;
            total++;
            if (pulse2[0] !== (e >= 4 && e <= 8))
                $display("FAIL both_pulse e=%0d got %b exp %b", e, pulse2[0], e >= 4 && e <= 8);
            else passed++;
        end
    endtask

    task automatic test_random();
        int rem[2];
        logic [12:0] got, exp;
        rem[0] = 0; rem[1] = 0;
        rst_n = 1'b0;
        key_in = 2'b11;
        evt_clr = 2'b00;
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (rem[i] == 0) begin
                    key_in[i] = 1'($urandom_range(0, 1));
                    rem[i] = $urandom_range(1, 18);
                end else begin
                    rem[i]--;
                end
            end
            evt_clr[0] = ($urandom_range(0, 9) == 0);
            evt_clr[1] = ($urandom_range(0, 9) == 0);
            tick();
            got = {level, pulse_out, long_pulse, evt_press, evt_release, evt_long, irq};
            exp = {m_level, m_pulse, m_long, m_fp, m_fr, m_fl, m_irq};
            total++;
            if (got !== exp) $display("FAIL random c=%0d got %b exp %b", c, got, exp);
            else passed++;
        end
        evt_clr = 2'b00;
    endtask

    initial begin
        test_reset();
        test_press_timing();
        test_long_press();
        test_bounce();
        test_clear();
        test_reset_mid();
        test_edge_both();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
